// File: rtl/rgmii_rx_decoder.sv
// RGMII receive decoder: turns DDR-captured nibble pairs into a GMII byte stream for 10/100/1000
// links, with preamble/SFD stripping, frame markers, in-band link status and frame/error counters.
module rgmii_rx_decoder #(
    parameter bit STRIP_PREAMBLE = 1'b1,
    parameter bit INBAND_STATUS  = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             gmii_rx_clk,
    input  logic             rst_n,
    input  logic [3:0]       ddr_data_h,
    input  logic [3:0]       ddr_data_l,
    input  logic             ddr_ctl_h,
    input  logic             ddr_ctl_l,
    input  logic [1:0]       speed_mode,
    output logic [7:0]       gmii_rx_data,
    output logic             gmii_rx_dv,
    output logic             gmii_rx_er,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic             align_err,
    output logic             link_up,
    output logic [1:0]       link_speed,
    output logic             full_duplex,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DROP, WAIT_IDLE} state_t;

    state_t     state, eff_state, next_state;
    logic       dv, er, dv_q, rise, gig, spd_gig, mode_gig;
    logic [7:0] in_byte;
    logic       is_pre, is_sfd;
    logic       half_vld, half_er;
    logic [3:0] half_data;
    logic       first_pend, frame_bad;
    logic       vld_p0, er_p0, sof_p0;
    logic [7:0] data_p0;
    logic       take_nib, byte_done, frame_end, emit, emit_align, bad_end;
    logic       drop_evt, pre_abort;
    logic [7:0] byte_val;
    logic       byte_er;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign dv       = ddr_ctl_h;
    assign er       = ddr_ctl_h ^ ddr_ctl_l;
    assign rise     = dv & ~dv_q;
    assign mode_gig = (speed_mode != 2'b00) && (speed_mode != 2'b01);
    // Speed is taken live on the DV rising cycle, then frozen for the rest of the frame.
    assign gig      = (state == IDLE) ? mode_gig : spd_gig;
    assign in_byte  = {ddr_data_l, ddr_data_h};
    assign is_sfd   = gig ? (in_byte == 8'hD5) : (ddr_data_h == 4'hD);
    assign is_pre   = gig ? (in_byte == 8'h55) : (ddr_data_h == 4'h5);

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // The DV rising cycle already carries the first byte/nibble, so it is handled as the target state.
    always_comb begin
        eff_state = state;
        if (state == IDLE && dv)
            eff_state = rise ? (STRIP_PREAMBLE ? PREAMBLE : DATA) : WAIT_IDLE;
        next_state = eff_state;
        case (eff_state)
            IDLE:      next_state = IDLE;
            PREAMBLE:  if (!dv) next_state = IDLE;
                       else if (is_sfd) next_state = DATA;
                       else if (!is_pre) next_state = DROP;
            DATA:      if (!dv) next_state = IDLE;
            DROP:      if (!dv) next_state = IDLE;
            WAIT_IDLE: if (!dv) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        take_nib  = 1'b0;
        byte_done = 1'b0;
        byte_val  = in_byte;
        byte_er   = er;
        frame_end = (eff_state == DATA) && !dv;
        if (eff_state == DATA && dv) begin
            if (gig) begin
                byte_done = 1'b1;
            end else if (half_vld) begin
                byte_done = 1'b1;
                byte_val  = {ddr_data_h, half_data};
                byte_er   = er | half_er;
            end else begin
                take_nib = 1'b1;
            end
        end
        emit       = vld_p0 && (byte_done || frame_end);
        emit_align = frame_end && half_vld;
        bad_end    = frame_bad | er_p0 | emit_align;
        drop_evt   = (next_state == DROP) && (eff_state != DROP);
        pre_abort  = (eff_state == PREAMBLE) && !dv;
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (take_nib) begin
            half_data <= ddr_data_h;
            half_er   <= er;
        end
        if (byte_done) data_p0 <= byte_val;
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q         <= 1'b1;
            spd_gig      <= 1'b0;
            half_vld     <= 1'b0;
            first_pend   <= 1'b1;
            frame_bad    <= 1'b0;
            vld_p0       <= 1'b0;
            er_p0        <= 1'b0;
            sof_p0       <= 1'b0;
            gmii_rx_data <= 8'h00;
            gmii_rx_dv   <= 1'b0;
            gmii_rx_er   <= 1'b0;
            rx_sof       <= 1'b0;
            rx_eof       <= 1'b0;
            align_err    <= 1'b0;
            frame_cnt    <= '0;
            err_cnt      <= '0;
        end else begin
            dv_q <= dv;
            if (state == IDLE) spd_gig <= mode_gig;

            // stage p0: one-byte hold buffer, released when the next byte completes or DV falls
            if (eff_state != DATA || frame_end) begin
                half_vld   <= 1'b0;
                first_pend <= 1'b1;
                frame_bad  <= 1'b0;
                vld_p0     <= 1'b0;
            end else begin
                if (take_nib) half_vld <= 1'b1;
                if (byte_done) begin
                    half_vld   <= 1'b0;
                    vld_p0     <= 1'b1;
                    first_pend <= 1'b0;
                    sof_p0     <= first_pend;
                    er_p0      <= byte_er;
                    if (emit) frame_bad <= frame_bad | er_p0;
                end
            end

            // stage p1: output registers
            gmii_rx_dv   <= emit;
            gmii_rx_data <= emit ? data_p0 : 8'h00;
            gmii_rx_er   <= emit & er_p0;
            rx_sof       <= emit & sof_p0;
            rx_eof       <= emit & frame_end;
            align_err    <= emit & emit_align;
            if (emit && frame_end) frame_cnt <= frame_cnt + CNT_W'(1);
            if (drop_evt || pre_abort || (emit && frame_end && bad_end))
                err_cnt <= sat_inc(err_cnt);
        end
    end

    generate
        if (INBAND_STATUS) begin : g_status
            always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
                if (!rst_n) begin
                    link_up     <= 1'b0;
                    link_speed  <= 2'b00;
                    full_duplex <= 1'b0;
                end else if (!ddr_ctl_h && !ddr_ctl_l) begin
                    link_up     <= ddr_data_h[0];
                    link_speed  <= ddr_data_h[2:1];
                    full_duplex <= ddr_data_h[3];
                end
            end
        end else begin : g_no_status
            assign link_up     = 1'b0;
            assign link_speed  = 2'b00;
            assign full_duplex = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Directed bench for rgmii_rx_decoder: a default instance (strip, in-band status) and a second
// instance with STRIP_PREAMBLE=0 / INBAND_STATUS=0 fed by the same RGMII inputs.
module tb_rgmii_rx_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ddr_data_h, ddr_data_l;
    logic        ddr_ctl_h, ddr_ctl_l;
    logic [1:0]  speed_mode;

    logic [7:0]  gmii_rx_data, b_data;
    logic        gmii_rx_dv, gmii_rx_er, rx_sof, rx_eof, align_err, link_up, full_duplex;
    logic        b_dv, b_er, b_sof, b_eof, b_align, b_link_up, b_full_duplex;
    logic [1:0]  link_speed, b_link_speed;
    logic [15:0] frame_cnt, err_cnt, b_frame_cnt, b_err_cnt;

    typedef struct packed {
        logic [7:0] d;
        logic       er;
        logic       sof;
        logic       eof;
        logic       al;
        int         t;
    } ent_t;

    ent_t q[$];
    ent_t qb[$];
    int   cyc_n = 0;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] status = 4'h0;
    int   t0;

    always #5 clk = ~clk;

    rgmii_rx_decoder #(.STRIP_PREAMBLE(1'b1), .INBAND_STATUS(1'b1), .CNT_W(16)) dut (
        .gmii_rx_clk(clk), .rst_n(rst_n),
        .ddr_data_h(ddr_data_h), .ddr_data_l(ddr_data_l),
        .ddr_ctl_h(ddr_ctl_h), .ddr_ctl_l(ddr_ctl_l), .speed_mode(speed_mode),
        .gmii_rx_data(gmii_rx_data), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .align_err(align_err),
        .link_up(link_up), .link_speed(link_speed), .full_duplex(full_duplex),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    rgmii_rx_decoder #(.STRIP_PREAMBLE(1'b0), .INBAND_STATUS(1'b0), .CNT_W(16)) dut_b (
        .gmii_rx_clk(clk), .rst_n(rst_n),
        .ddr_data_h(ddr_data_h), .ddr_data_l(ddr_data_l),
        .ddr_ctl_h(ddr_ctl_h), .ddr_ctl_l(ddr_ctl_l), .speed_mode(speed_mode),
        .gmii_rx_data(b_data), .gmii_rx_dv(b_dv), .gmii_rx_er(b_er),
        .rx_sof(b_sof), .rx_eof(b_eof), .align_err(b_align),
        .link_up(b_link_up), .link_speed(b_link_speed), .full_duplex(b_full_duplex),
        .frame_cnt(b_frame_cnt), .err_cnt(b_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One RXC cycle; every emitted byte is logged with the number of the call that exposed it.
    task automatic cyc(input logic [3:0] dh, input logic [3:0] dl, input logic ch, input logic cl);
        ent_t e;
        ddr_data_h = dh;
        ddr_data_l = dl;
        ddr_ctl_h  = ch;
        ddr_ctl_l  = cl;
        @(posedge clk);
        #1;
        cyc_n++;
        if (gmii_rx_dv) begin
            e.d = gmii_rx_data; e.er = gmii_rx_er; e.sof = rx_sof; e.eof = rx_eof;
            e.al = align_err; e.t = cyc_n;
            q.push_back(e);
        end
        if (b_dv) begin
            e.d = b_data; e.er = b_er; e.sof = b_sof; e.eof = b_eof; e.al = b_align; e.t = cyc_n;
            qb.push_back(e);
        end
    endtask

    task automatic gbyte(input logic [7:0] b, input logic err);
        cyc(b[3:0], b[7:4], 1'b1, ~err);
    endtask

    task automatic nib(input logic [3:0] n);
        cyc(n, 4'h0, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(status, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic chk_ent(input string tag, input bit use_b, input int idx, input logic [7:0] d,
                           input logic er, input logic sof, input logic eof, input logic al,
                           input int t);
        ent_t e;
        e = '1;
        if (!use_b && idx < q.size())  e = q[idx];
        if (use_b  && idx < qb.size()) e = qb[idx];
        chk({tag, " flags"}, {20'h0, e.d, e.er, e.sof, e.eof, e.al}, {20'h0, d, er, sof, eof, al});
        chk({tag, " time"}, e.t, t);
    endtask

    initial begin
        rst_n = 1'b0;
        speed_mode = 2'b10;
        cyc(4'h0, 4'h0, 1'b0, 1'b0);
        cyc(4'h0, 4'h0, 1'b0, 1'b0);
        cyc(4'h0, 4'h0, 1'b0, 1'b0);
        chk("reset outputs", {19'h0, gmii_rx_data, gmii_rx_dv, gmii_rx_er, rx_sof, rx_eof, align_err,
                              link_up, link_speed, full_duplex},
            32'h0);
        chk("reset frame_cnt", frame_cnt, 0);
        chk("reset err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        idle(3);

        // 1000 Mb/s, 64-byte payload; a byte given in call k shows up at the end of call k+1
        q.delete(); qb.delete();
        repeat (7) gbyte(8'h55, 1'b0);
        gbyte(8'hD5, 1'b0);
        t0 = cyc_n + 1;
        for (int i = 1; i <= 64; i++) gbyte(8'(i), 1'b0);
        idle(4);
        chk("g1 count", q.size(), 64);
        for (int i = 0; i < 64; i++)
            chk_ent($sformatf("g1 byte %0d", i), 1'b0, i, 8'(i + 1), 1'b0, i == 0, i == 63, 1'b0,
                    t0 + i + 1);
        chk("g1 frame_cnt", frame_cnt, 1);
        chk("g1 err_cnt", err_cnt, 0);
        chk("g1 b count", qb.size(), 72);
        chk_ent("g1 b first", 1'b1, 0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, t0 - 7);

        // 100 Mb/s nibble assembly
        q.delete();
        speed_mode = 2'b01;
        repeat (15) nib(4'h5);
        nib(4'hD);
        t0 = cyc_n + 1;
        nib(4'hA); nib(4'hB); nib(4'hC); nib(4'hD);
        idle(4);
        chk("m100 count", q.size(), 2);
        chk_ent("m100 b0", 1'b0, 0, 8'hBA, 1'b0, 1'b1, 1'b0, 1'b0, t0 + 3);
        chk_ent("m100 b1", 1'b0, 1, 8'hDC, 1'b0, 1'b0, 1'b1, 1'b0, t0 + 4);
        chk("m100 frame_cnt", frame_cnt, 2);
        chk("m100 err_cnt", err_cnt, 0);

        // 10 Mb/s with a trailing odd nibble
        q.delete();
        speed_mode = 2'b00;
        repeat (15) nib(4'h5);
        nib(4'hD);
        t0 = cyc_n + 1;
        nib(4'h1); nib(4'h2); nib(4'h3);
        idle(4);
        chk("m10 count", q.size(), 1);
        chk_ent("m10 b0", 1'b0, 0, 8'h21, 1'b0, 1'b1, 1'b1, 1'b1, t0 + 3);
        chk("m10 frame_cnt", frame_cnt, 3);
        chk("m10 err_cnt", err_cnt, 1);

        // 1000 Mb/s with RX_ER on the 5th payload byte
        q.delete();
        speed_mode = 2'b10;
        repeat (7) gbyte(8'h55, 1'b0);
        gbyte(8'hD5, 1'b0);
        t0 = cyc_n + 1;
        for (int i = 0; i < 8; i++) gbyte(8'(8'h10 + i), i == 4);
        idle(4);
        chk("er count", q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_ent($sformatf("er byte %0d", i), 1'b0, i, 8'(8'h10 + i), i == 4, i == 0, i == 7, 1'b0,
                    t0 + i + 1);
        chk("er frame_cnt", frame_cnt, 4);
        chk("er err_cnt", err_cnt, 2);

        // Bad preamble: dropped by the stripping instance, passed whole by the other
        q.delete(); qb.delete();
        t0 = cyc_n + 1;
        gbyte(8'h55, 1'b0); gbyte(8'h55, 1'b0); gbyte(8'h5A, 1'b0);
        gbyte(8'h11, 1'b0); gbyte(8'h22, 1'b0);
        idle(4);
        chk("badpre count", q.size(), 0);
        chk("badpre err_cnt", err_cnt, 3);
        chk("badpre frame_cnt", frame_cnt, 4);
        chk("badpre b count", qb.size(), 5);
        chk_ent("badpre b0", 1'b1, 0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, t0 + 1);
        chk_ent("badpre b1", 1'b1, 1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, t0 + 2);
        chk_ent("badpre b2", 1'b1, 2, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, t0 + 3);
        chk_ent("badpre b3", 1'b1, 3, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, t0 + 4);
        chk_ent("badpre b4", 1'b1, 4, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, t0 + 5);
        chk("badpre b frame_cnt", b_frame_cnt, 5);

        // DV falls inside the preamble
        q.delete();
        gbyte(8'h55, 1'b0); gbyte(8'h55, 1'b0);
        idle(4);
        chk("preabort count", q.size(), 0);
        chk("preabort err_cnt", err_cnt, 4);
        chk("preabort frame_cnt", frame_cnt, 4);

        // Two one-byte frames separated by a single idle cycle
        q.delete();
        gbyte(8'h55, 1'b0); gbyte(8'hD5, 1'b0);
        t0 = cyc_n + 1;
        gbyte(8'hA1, 1'b0);
        idle(1);
        gbyte(8'h55, 1'b0); gbyte(8'hD5, 1'b0); gbyte(8'hB2, 1'b0);
        idle(4);
        chk("b2b count", q.size(), 2);
        chk_ent("b2b f0", 1'b0, 0, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, t0 + 1);
        chk_ent("b2b f1", 1'b0, 1, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b0, t0 + 5);
        chk("b2b frame_cnt", frame_cnt, 6);

        // In-band status during idle
        status = 4'b1101;
        idle(2);
        chk("status link_up", link_up, 1);
        chk("status link_speed", link_speed, 2'b10);
        chk("status full_duplex", full_duplex, 1);
        chk("status b tied", {b_link_up, b_link_speed, b_full_duplex}, 0);

        // Reset in the middle of a frame, released while DV is still high
        gbyte(8'h55, 1'b0); gbyte(8'hD5, 1'b0);
        gbyte(8'h01, 1'b0); gbyte(8'h02, 1'b0); gbyte(8'h03, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst outputs", {19'h0, gmii_rx_data, gmii_rx_dv, gmii_rx_er, rx_sof, rx_eof, align_err,
                               link_up, link_speed, full_duplex},
            32'h0);
        chk("midrst frame_cnt", frame_cnt, 0);
        chk("midrst err_cnt", err_cnt, 0);
        q.delete();
        gbyte(8'h04, 1'b0);
        rst_n = 1'b1;
        gbyte(8'h05, 1'b0); gbyte(8'h06, 1'b0); gbyte(8'h07, 1'b0);
        idle(3);
        chk("postrst count", q.size(), 0);
        chk("postrst frame_cnt", frame_cnt, 0);
        gbyte(8'h55, 1'b0); gbyte(8'hD5, 1'b0);
        t0 = cyc_n + 1;
        gbyte(8'h77, 1'b0);
        idle(3);
        chk("postrst2 count", q.size(), 1);
        chk_ent("postrst2 b0", 1'b0, 0, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, t0 + 1);
        chk("postrst2 frame_cnt", frame_cnt, 1);
        chk("postrst2 err_cnt", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
